// File: rtl/byte_frame_receiver.sv
// Byte-level frame receiver: finds 0x55 preamble + SFD, extracts a length-prefixed
// payload, verifies an 8-bit additive checksum and keeps good/bad frame counters.
module byte_frame_receiver #(
  parameter int         PRE_MIN = 1,
  parameter logic [7:0] SFD     = 8'hD5,
  parameter int         MAX_LEN = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_active,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        pay_sof,
  output logic        pay_eof,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HUNT    = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  localparam logic [7:0] PREAMBLE  = 8'h55;
  localparam logic [3:0] PRE_MIN_B = 4'(PRE_MIN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0] E_PRE     = 2'd0;
  localparam logic [1:0] E_LEN     = 2'd1;
  localparam logic [1:0] E_CSUM    = 2'd2;
  localparam logic [1:0] E_TRUNC   = 2'd3;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_pre_cnt, w_pre_cnt_nxt;
  logic [7:0]  r_rem, w_rem_nxt;
  logic [7:0]  r_sum, w_sum_nxt;
  logic        r_first, w_first_nxt;
  logic [7:0]  r_pay_data, w_pay_data_nxt;
  logic        r_pay_valid, w_pay_valid_nxt;
  logic        r_pay_sof, w_pay_sof_nxt;
  logic        r_pay_eof, w_pay_eof_nxt;
  logic        r_frame_ok, w_ok;
  logic        r_frame_err, w_err;
  logic [1:0]  r_err_code, w_code_nxt;
  logic [15:0] r_frame_cnt, w_frame_cnt_nxt;
  logic [15:0] r_err_cnt, w_err_cnt_nxt;

  // Payload handshake: pay_valid is a one-cycle strobe with no ready; the
  // consumer must take every strobe and drop the frame if frame_err follows.
  always_comb begin
    w_state_nxt     = r_state;
    w_pre_cnt_nxt   = r_pre_cnt;
    w_rem_nxt       = r_rem;
    w_sum_nxt       = r_sum;
    w_first_nxt     = r_first;
    w_pay_data_nxt  = r_pay_data;
    w_pay_valid_nxt = 1'b0;
    w_pay_sof_nxt   = 1'b0;
    w_pay_eof_nxt   = 1'b0;
    w_ok            = 1'b0;
    w_err           = 1'b0;
    w_code_nxt      = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (frame_active) begin
          w_state_nxt   = S_HUNT;
          w_pre_cnt_nxt = 4'd0;
        end
      end
      S_HUNT: begin
        // Losing frame_active here is just an idle line, not an error.
        if (!frame_active) begin
          w_state_nxt = S_IDLE;
        end else if (byte_valid) begin
          if (byte_in == PREAMBLE) begin
            if (r_pre_cnt != 4'hF) w_pre_cnt_nxt = r_pre_cnt + 4'd1;
          end else if (byte_in == SFD && r_pre_cnt >= PRE_MIN_B) begin
            w_state_nxt = S_LEN;
          end else begin
            w_err       = 1'b1;
            w_code_nxt  = E_PRE;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_LEN: begin
        if (!frame_active) begin
          w_err       = 1'b1;
          w_code_nxt  = E_TRUNC;
          w_state_nxt = S_IDLE;
        end else if (byte_valid) begin
          if (byte_in == 8'd0 || byte_in > MAX_LEN_B) begin
            w_err       = 1'b1;
            w_code_nxt  = E_LEN;
            w_state_nxt = S_DRAIN;
          end else begin
            w_rem_nxt   = byte_in;
            w_sum_nxt   = byte_in;
            w_first_nxt = 1'b1;
            w_state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (!frame_active) begin
          w_err       = 1'b1;
          w_code_nxt  = E_TRUNC;
          w_state_nxt = S_IDLE;
        end else if (byte_valid) begin
          w_pay_valid_nxt = 1'b1;
          w_pay_data_nxt  = byte_in;
          w_pay_sof_nxt   = r_first;
          w_first_nxt     = 1'b0;
          w_sum_nxt       = r_sum + byte_in;
          w_rem_nxt       = r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            w_pay_eof_nxt = 1'b1;
            w_state_nxt   = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (!frame_active) begin
          w_err       = 1'b1;
          w_code_nxt  = E_TRUNC;
          w_state_nxt = S_IDLE;
        end else if (byte_valid) begin
          if (byte_in == r_sum) begin
            w_ok = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_code_nxt = E_CSUM;
          end
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!frame_active) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters are rewritten every cycle so their held value always tracks the register.
  assign w_frame_cnt_nxt = r_frame_cnt + {15'd0, w_ok};
  assign w_err_cnt_nxt   = r_err_cnt + {15'd0, w_err};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pre_cnt   <= 4'd0;
      r_rem       <= 8'd0;
      r_sum       <= 8'd0;
      r_first     <= 1'b0;
      r_pay_data  <= 8'd0;
      r_pay_valid <= 1'b0;
      r_pay_sof   <= 1'b0;
      r_pay_eof   <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'd0;
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_rem       <= w_rem_nxt;
      r_sum       <= w_sum_nxt;
      r_first     <= w_first_nxt;
      r_pay_data  <= w_pay_data_nxt;
      r_pay_valid <= w_pay_valid_nxt;
      r_pay_sof   <= w_pay_sof_nxt;
      r_pay_eof   <= w_pay_eof_nxt;
      r_frame_ok  <= w_ok;
      r_frame_err <= w_err;
      r_err_code  <= w_code_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign pay_data  = r_pay_data;
  assign pay_valid = r_pay_valid;
  assign pay_sof   = r_pay_sof;
  assign pay_eof   = r_pay_eof;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_byte_frame_receiver.sv
// Directed bench for byte_frame_receiver: expected payload strobes and status
// pulses are queued by the stimulus and checked by an independent monitor.
module tb_byte_frame_receiver;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_active = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  pay_data;
  logic        pay_valid, pay_sof, pay_eof, frame_ok, frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt, err_cnt;
  logic [2:0]  dbg_state;

  byte_frame_receiver #(.PRE_MIN(1), .SFD(8'hD5), .MAX_LEN(64)) dut (
    .clock(clock), .reset_n(reset_n), .frame_active(frame_active),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_sof(pay_sof), .pay_eof(pay_eof),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [9:0]  exp_pay_q[$];   // {sof, eof, data}
  logic [35:0] exp_stat_q[$];  // {ok, err, code, frame_cnt, err_cnt}
  logic [7:0]  tx_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_bad  = 16'd0;
  logic [1:0]  exp_code = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_pay(input logic sof, input logic eof, input logic [7:0] d);
    exp_pay_q.push_back({sof, eof, d});
  endtask

  task automatic exp_ok();
    exp_good = exp_good + 16'd1;
    exp_stat_q.push_back({1'b1, 1'b0, exp_code, exp_good, exp_bad});
  endtask

  task automatic exp_err(input logic [1:0] code);
    exp_bad  = exp_bad + 16'd1;
    exp_code = code;
    exp_stat_q.push_back({1'b0, 1'b1, exp_code, exp_good, exp_bad});
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic [9:0]  mon_pay;
  logic [35:0] mon_stat;
  always @(negedge clock) begin
    if (mon_en) begin
      if (pay_valid) begin
        checks++;
        if (exp_pay_q.size() == 0) begin
          errors++;
          $display("FAIL pay_unexpected actual=%0h required=none", {pay_sof, pay_eof, pay_data});
        end else begin
          mon_pay = exp_pay_q.pop_front();
          if ({pay_sof, pay_eof, pay_data} !== mon_pay) begin
            errors++;
            $display("FAIL pay actual=%0h required=%0h", {pay_sof, pay_eof, pay_data}, mon_pay);
          end
        end
      end
      if (frame_ok || frame_err) begin
        checks++;
        if (exp_stat_q.size() == 0) begin
          errors++;
          $display("FAIL status_unexpected actual=%0h required=none",
                   {frame_ok, frame_err, err_code, frame_cnt, err_cnt});
        end else begin
          mon_stat = exp_stat_q.pop_front();
          if ({frame_ok, frame_err, err_code, frame_cnt, err_cnt} !== mon_stat) begin
            errors++;
            $display("FAIL status actual=%0h required=%0h",
                     {frame_ok, frame_err, err_code, frame_cnt, err_cnt}, mon_stat);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Upstream changes inputs on the falling edge; the DUT samples on the rising edge.
  task automatic drive(input logic fa, input logic bv, input logic [7:0] b);
    @(negedge clock);
    frame_active = fa;
    byte_valid   = bv;
    byte_in      = b;
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_q();
    foreach (tx_q[i]) drive(1'b1, 1'b1, tx_q[i]);
  endtask

  task automatic end_frame();
    drive(1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clock);
    chk("reset_outputs", {pay_data, pay_valid, pay_sof, pay_eof, frame_ok, frame_err, err_code},
        64'd0);
    chk("reset_counters", {frame_cnt, err_cnt}, 64'd0);
    chk("reset_state", dbg_state, 64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Good frame; checksum covers the length byte: 03+11+22+33 = 69.
    exp_pay(1'b1, 1'b0, 8'h11); exp_pay(1'b0, 1'b0, 8'h22); exp_pay(1'b0, 1'b1, 8'h33);
    exp_ok();
    start_frame();
    tx_q = '{8'h55, 8'h55, 8'hD5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_q();
    end_frame();

    // Same payload, wrong checksum.
    exp_pay(1'b1, 1'b0, 8'h11); exp_pay(1'b0, 1'b0, 8'h22); exp_pay(1'b0, 1'b1, 8'h33);
    exp_err(2'd2);
    start_frame();
    tx_q = '{8'h55, 8'h55, 8'hD5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
    send_q();
    end_frame();

    // SFD with no preamble, then a single-byte frame (01+AA = AB).
    exp_err(2'd0);
    start_frame();
    tx_q = '{8'hD5};
    send_q();
    end_frame();
    exp_pay(1'b1, 1'b1, 8'hAA);
    exp_ok();
    start_frame();
    tx_q = '{8'h55, 8'hD5, 8'h01, 8'hAA, 8'hAB};
    send_q();
    end_frame();

    // Illegal lengths 0 and 65.
    exp_err(2'd1);
    start_frame();
    tx_q = '{8'h55, 8'hD5, 8'h00, 8'h12};
    send_q();
    end_frame();
    exp_err(2'd1);
    start_frame();
    tx_q = '{8'h55, 8'hD5, 8'h41, 8'h12};
    send_q();
    end_frame();

    // Truncation after 2 of 3 payload bytes; the byte_valid on the drop cycle is ignored.
    exp_pay(1'b1, 1'b0, 8'h11); exp_pay(1'b0, 1'b0, 8'h22);
    exp_err(2'd3);
    start_frame();
    tx_q = '{8'h55, 8'hD5, 8'h03, 8'h11, 8'h22};
    send_q();
    drive(1'b0, 1'b1, 8'h33);
    drive(1'b0, 1'b0, 8'h00);
    chk("trunc_state_idle", dbg_state, 64'd0);
    chk("trunc_err_code", err_code, 64'd3);

    // Reset in the middle of a payload: everything clears, no pulse.
    exp_pay(1'b1, 1'b0, 8'h11);
    start_frame();
    tx_q = '{8'h55, 8'hD5, 8'h03, 8'h11};
    send_q();
    @(negedge clock);
    reset_n = 1'b0;
    byte_in = 8'h22;
    @(negedge clock);
    chk("midreset_outputs", {pay_data, pay_valid, pay_sof, pay_eof, frame_ok, frame_err, err_code},
        64'd0);
    chk("midreset_counters", {frame_cnt, err_cnt}, 64'd0);
    chk("midreset_state", dbg_state, 64'd0);
    reset_n  = 1'b1;
    exp_good = 16'd0;
    exp_bad  = 16'd0;
    exp_code = 2'd0;
    end_frame();

    // Counter wrap from 0xFFFF; trailing bytes after the checksum are ignored.
    force dut.r_frame_cnt = 16'hFFFF;
    repeat (2) @(negedge clock);
    release dut.r_frame_cnt;
    exp_good = 16'hFFFF;
    exp_pay(1'b1, 1'b0, 8'h10); exp_pay(1'b0, 1'b1, 8'h20);
    exp_ok();
    start_frame();
    tx_q = '{8'h55, 8'hD5, 8'h02, 8'h10, 8'h20, 8'h32, 8'h55, 8'hD5, 8'h07};
    send_q();
    end_frame();
    drive(1'b0, 1'b0, 8'h00);
    chk("wrap_frame_cnt", frame_cnt, 64'd0);
    chk("trailing_err_cnt", err_cnt, 64'd0);

    repeat (4) drive(1'b0, 1'b0, 8'h00);
    chk("pay_queue_drained", exp_pay_q.size(), 64'd0);
    chk("status_queue_drained", exp_stat_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
